// File: rtl/matrix_merge_64_top.sv
// Purpose : reassembles sixteen 16x16 result tiles into one 64x64 matrix register.
// Latency : a tile shows on matrix_o one cycle after its transfer; finish_o one cycle after the last tile.
// Backpres: tile_ready_o is high only while collecting; the sender holds a tile until it is taken.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   en_i                 arm a new collection (honoured in IDLE/DONE only)
//   tile_valid_i/_ready_o  tile handshake; tile_idx_i selects tile k, tile_data_i carries it
//   matrix_o             64x64 signed matrix, element (i,j) at [(i*64+j)*DW +: DW]
//   busy_o / finish_o    collecting / collection complete (level)
//   err_dup_o            pulse in the cycle a duplicate tile is accepted and dropped
// Build option MERGE_ANY_ORDER_EN: place tiles by tile_idx_i in any order with duplicate
// detection. Without it tiles are placed 0..15 in arrival order and tile_idx_i is ignored.
// Tile k covers row block k%GRID and column block k/GRID (column-major, splitter order).

module matrix_merge_64_top #(
    parameter int DW   = 16,
    parameter int TILE = 16,
    parameter int GRID = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                en_i,
    input  logic                                tile_valid_i,
    output logic                                tile_ready_o,
    input  logic [$clog2(GRID*GRID)-1:0]        tile_idx_i,
    input  logic [TILE*TILE*DW-1:0]             tile_data_i,
    output logic [TILE*GRID*TILE*GRID*DW-1:0]   matrix_o,
    output logic                                busy_o,
    output logic                                finish_o,
    output logic                                err_dup_o
);

    localparam int NT     = GRID * GRID;
    localparam int IDXW   = $clog2(NT);
    localparam int EDGE   = TILE * GRID;
    localparam int TILE_W = TILE * TILE * DW;
    localparam int ROW_W  = TILE * DW;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NT-1:0]   mask_q, mask_d;
    logic [IDXW-1:0] k;
    logic            xfer;
    logic            dup;
    logic            wr_en;

    assign tile_ready_o = (state_q == S_COLLECT);
    assign busy_o       = (state_q == S_COLLECT);
    assign finish_o     = (state_q == S_DONE);
    assign xfer         = tile_valid_i & tile_ready_o;

`ifdef MERGE_ANY_ORDER_EN
    assign k   = tile_idx_i;
    assign dup = mask_q[k];
`else
    // Arrival counter supplies the tile number; cleared whenever a collection is armed.
    logic [IDXW-1:0] cnt_q;
    logic            unused_idx;

    assign unused_idx = ^tile_idx_i;
    assign k          = cnt_q;
    assign dup        = 1'b0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if ((state_q != S_COLLECT) && en_i) begin
            cnt_q <= '0;
        end else if (xfer) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`endif

    // A duplicate is still handshaken (the sender must not stall) but never written.
    assign wr_en     = xfer & ~dup;
    assign err_dup_o = xfer & dup;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (en_i) begin
                    mask_d  = '0;
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (wr_en) begin
                    mask_d = mask_q | (NT'(1) << k);
                    if (&mask_d) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
        end
    end

    // One storage register per tile; each tile row is a contiguous run of TILE elements
    // inside a matrix row, so the matrix output is pure wiring of these slices.
    for (genvar t = 0; t < NT; t++) begin : g_tile
        logic [TILE_W-1:0] slice_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                slice_q <= '0;
            end else if (wr_en && (k == IDXW'(t))) begin
                slice_q <= tile_data_i;
            end
        end

        for (genvar a = 0; a < TILE; a++) begin : g_row
            assign matrix_o[(((t % GRID) * TILE + a) * EDGE + (t / GRID) * TILE) * DW +: ROW_W] =
                slice_q[a * ROW_W +: ROW_W];
        end
    end

endmodule

// File: tb/tb_matrix_merge_64_top.sv
module tb_matrix_merge_64_top;

    localparam int TW = 4096;
    localparam int MW = 65536;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b0;
    logic          tile_valid = 1'b0;
    logic          tile_ready;
    logic [3:0]    tile_idx = 4'd0;
    logic [TW-1:0] tile_data = '0;
    logic [MW-1:0] matrix;
    logic          busy, finish, err_dup;

    int n_vec = 0;
    int n_err = 0;

    matrix_merge_64_top dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .tile_valid_i(tile_valid),
        .tile_ready_o(tile_ready),
        .tile_idx_i  (tile_idx),
        .tile_data_i (tile_data),
        .matrix_o    (matrix),
        .busy_o      (busy),
        .finish_o    (finish),
        .err_dup_o   (err_dup)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (element-level) ----------------
    logic [15:0] mdl [64][64];
    bit          got [16];
    int          mdl_cnt;

    typedef struct {
        int            k;
        bit            dup;
        bit            fin;
        logic [TW-1:0] slice;
    } exp_t;

    exp_t sb_q[$];

    function automatic logic [TW-1:0] mdl_slice(int k);
        logic [TW-1:0] s;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                s[(a*16+b)*16 +: 16] = mdl[16*(k%4)+a][16*(k/4)+b];
        return s;
    endfunction

    function automatic logic [15:0] dut_el(int i, int j);
        return matrix[(i*64+j)*16 +: 16];
    endfunction

    function automatic logic [TW-1:0] dut_slice(int k);
        logic [TW-1:0] s;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                s[(a*16+b)*16 +: 16] = dut_el(16*(k%4)+a, 16*(k/4)+b);
        return s;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 64; i++)
            for (int j = 0; j < 64; j++)
                mdl[i][j] = 16'h0;
        for (int k = 0; k < 16; k++) got[k] = 1'b0;
        mdl_cnt = 0;
    endtask

    task automatic mdl_arm();
        for (int k = 0; k < 16; k++) got[k] = 1'b0;
        mdl_cnt = 0;
    endtask

    task automatic mdl_accept(input int k_in, input logic [TW-1:0] d, output exp_t e);
        int  k;
        bit  all;
`ifdef MERGE_ANY_ORDER_EN
        k     = k_in;
        e.dup = got[k];
`else
        k       = mdl_cnt;
        mdl_cnt = (mdl_cnt + 1) % 16;
        e.dup   = 1'b0;
`endif
        if (!e.dup) begin
            got[k] = 1'b1;
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    mdl[16*(k%4)+a][16*(k/4)+b] = d[(a*16+b)*16 +: 16];
        end
        all = 1'b1;
        for (int t = 0; t < 16; t++) if (!got[t]) all = 1'b0;
        e.k     = k;
        e.fin   = all;
        e.slice = mdl_slice(k);
    endtask

    // ---------------- checks ----------------
    task automatic check_int(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic check_mat(input string nm, input bit formula);
        int          bad = 0;
        int          fi = 0, fj = 0;
        logic [15:0] ev, fa = 16'h0, fe = 16'h0;
        for (int i = 0; i < 64; i++) begin
            for (int j = 0; j < 64; j++) begin
                ev = formula ? 16'((((j/16)*4 + (i/16))*256) + (i%16)*16 + (j%16)) : mdl[i][j];
                if (dut_el(i, j) !== ev) begin
                    if (bad == 0) begin fi = i; fj = j; fa = dut_el(i, j); fe = ev; end
                    bad++;
                end
            end
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL %s: %0d elements differ, first (%0d,%0d) got %h expected %h",
                     nm, bad, fi, fj, fa, fe);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t cur;
        bit   pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
                continue;
            end
            if (pend) begin
                n_vec++;
                if (dut_slice(cur.k) !== cur.slice) begin
                    n_err++;
                    $display("FAIL slice_k%0d: tile contents on matrix differ from expected", cur.k);
                end
                check_int($sformatf("finish_after_k%0d", cur.k), int'(finish), int'(cur.fin));
                pend = 1'b0;
            end
            if (tile_valid && tile_ready) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_xfer: got transfer expected none");
                end else begin
                    cur = sb_q.pop_front();
                    check_int($sformatf("err_dup_k%0d", cur.k), int'(err_dup), int'(cur.dup));
                    pend = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    function automatic logic [TW-1:0] pat_tile(int k);
        logic [TW-1:0] t;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                t[(a*16+b)*16 +: 16] = 16'(k*256 + a*16 + b);
        return t;
    endfunction

    function automatic logic [TW-1:0] rand_tile();
        logic [TW-1:0] t;
        for (int e = 0; e < 256; e++) t[e*16 +: 16] = 16'($urandom);
        return t;
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the transfer edge.
    task automatic send(input int k, input logic [TW-1:0] d, input bit gap);
        exp_t e;
        bit   ok = 1'b0;
        mdl_accept(k, d, e);
        sb_q.push_back(e);
        tile_valid = 1'b1;
        tile_idx   = 4'(k);
        tile_data  = d;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (tile_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk);
        #1;
        tile_valid = 1'b0;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout_k%0d: got tile_ready=0 expected 1", k);
            void'(sb_q.pop_back());
        end
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic arm();
        en = 1'b1;
        mdl_arm();
        @(posedge clk);
        #1;
        en = 1'b0;
        check_int("arm_busy", int'(busy), 1);
        check_int("arm_ready", int'(tile_ready), 1);
        check_int("arm_finish", int'(finish), 0);
    endtask

    int ord[16];

    // ord = given prefix followed by the remaining tile numbers in random order
    task automatic make_order(input int p0, input int p1, input int p2, input int npre);
        int q[$];
        int pre[3];
        int tmp, r;
        bit used;
        pre[0] = p0; pre[1] = p1; pre[2] = p2;
        for (int i = 0; i < npre; i++) q.push_back(pre[i]);
        for (int t = 0; t < 16; t++) begin
            used = 1'b0;
            for (int i = 0; i < npre; i++) if (pre[i] == t) used = 1'b1;
            if (!used) q.push_back(t);
        end
        for (int i = 0; i < 16; i++) ord[i] = q[i];
        for (int i = 15; i > npre; i--) begin
            r = npre + int'($urandom_range(i - npre));
            tmp = ord[i]; ord[i] = ord[r]; ord[r] = tmp;
        end
    endtask

    initial begin : main
        mdl_reset();
        // 1: reset with tile_valid high
        tile_valid = 1'b1;
        tile_data  = rand_tile();
        #3 rst_n = 1'b0;
        #20;
        check_int("rst_ready", int'(tile_ready), 0);
        check_int("rst_finish", int'(finish), 0);
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_err_dup", int'(err_dup), 0);
        check_mat("rst_matrix", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_int("idle_ready", int'(tile_ready), 0);
        check_int("idle_busy", int'(busy), 0);
        tile_valid = 1'b0;

        // 2: in-order back-to-back with the index pattern
        arm();
        for (int k = 0; k < 16; k++) send(k, pat_tile(k), 1'b0);
        check_int("done_finish", int'(finish), 1);
        check_int("done_ready", int'(tile_ready), 0);
        check_int("done_busy", int'(busy), 0);
        check_mat("inorder_matrix", 1'b1);
        @(posedge clk);
        #1;
        check_int("done_finish_hold", int'(finish), 1);

`ifdef MERGE_ANY_ORDER_EN
        // 3: any order with valid toggling
        arm();
        make_order(15, 0, 7, 3);
        for (int i = 0; i < 16; i++) send(ord[i], pat_tile(ord[i]), 1'b1);
        check_int("anyorder_finish", int'(finish), 1);
        check_int("anyorder_ready", int'(tile_ready), 0);
        check_mat("anyorder_matrix", 1'b1);

        // 4: duplicate k=3
        arm();
        send(3, rand_tile(), 1'b0);
        send(3, {256{16'h7FFF}}, 1'b0);
        check_int("dup_busy", int'(busy), 1);
        make_order(3, 0, 0, 1);
        for (int i = 1; i < 16; i++) send(ord[i], rand_tile(), ($urandom_range(1) == 1));
        check_int("dup_finish", int'(finish), 1);
        check_mat("dup_matrix", 1'b0);
`else
        // 3: in-order with random data and valid gaps
        arm();
        for (int k = 0; k < 16; k++) send(15 - k, rand_tile(), ($urandom_range(1) == 1));
        check_int("rand_finish", int'(finish), 1);
        check_mat("rand_matrix", 1'b0);
`endif

        // 5: reset mid-collection after 9 tiles
        arm();
        make_order(0, 0, 0, 0);
        for (int i = 0; i < 9; i++) send(ord[i], rand_tile(), 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        mdl_reset();
        #1;
        check_int("midrst_ready", int'(tile_ready), 0);
        check_int("midrst_busy", int'(busy), 0);
        check_int("midrst_finish", int'(finish), 0);
        check_mat("midrst_matrix", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        arm();
        make_order(0, 0, 0, 0);
        for (int i = 0; i < 16; i++) send(ord[i], rand_tile(), 1'b0);
        check_int("rearm_finish", int'(finish), 1);
        check_mat("rearm_matrix", 1'b0);

        // 6: re-arm from DONE and replace a single tile
        @(posedge clk);
        #1;
        arm();
        send(5, rand_tile(), 1'b0);
        @(posedge clk);
        #1;
        check_int("partial_busy", int'(busy), 1);
        check_int("partial_finish", int'(finish), 0);
        check_mat("partial_matrix", 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check_int("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
